// File: rtl/fetch_queue_if.sv
// Bus and pipeline-side signal bundle for fetch_queue.
// The slave modport is the fetch queue; the master modport is its environment.
interface fetch_queue_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               flush_i;
   logic [ADDR_W-1:0]  flush_pc_i;
   logic               req_o;
   logic [ADDR_W-1:0]  req_addr_o;
   logic               req_ready_i;
   logic               resp_valid_i;
   logic [INSTR_W-1:0] resp_data_i;
   logic               instr_valid_o;
   logic [INSTR_W-1:0] instr_o;
   logic [ADDR_W-1:0]  instr_pc_o;
   logic               instr_ready_i;
   logic               misalign_o;
   logic [CNT_W-1:0]   count_o;

   modport slave (
      input  flush_i, flush_pc_i, req_ready_i, resp_valid_i, resp_data_i, instr_ready_i,
      output req_o, req_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o, count_o
   );

   modport master (
      output flush_i, flush_pc_i, req_ready_i, resp_valid_i, resp_data_i, instr_ready_i,
      input  req_o, req_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o, count_o
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch buffer: pipelined sequential bus requests, a PC-tagged FIFO,
// and redirect handling that silently drops responses still in flight.
module fetch_queue #(
   parameter int                ADDR_W    = 64,
   parameter int                INSTR_W   = 32,
   parameter int                DEPTH     = 4,
   parameter int                MAX_OUTST = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(64'h0000_0000_8000_0000)
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_queue_if.slave  fq
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int OUT_W = $clog2(MAX_OUTST + 1);
   localparam int PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int SUM_W = CNT_W + 1;
   localparam int INC   = INSTR_W / 8;

   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_fifo_data [DEPTH];
   logic [ADDR_W-1:0]  r_fifo_pc   [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [OUT_W-1:0]   r_outst;
   logic [OUT_W-1:0]   r_discard;
   logic [ADDR_W-1:0]  r_pend_pc   [MAX_OUTST];
   logic [PW-1:0]      r_pend_wr;
   logic [PW-1:0]      r_pend_rd;
   logic               r_misalign;

   logic w_credit;
   logic w_req;
   logic w_accept;
   logic w_resp;
   logic w_drop;
   logic w_push;
   logic w_valid;
   logic w_pop;

   function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
   endfunction

   // Every accepted request reserves a FIFO slot, so responses can never overflow it.
   assign w_credit = ({1'b0, r_count} + SUM_W'(r_outst)) < SUM_W'(DEPTH);
   assign w_req    = !fq.flush_i && w_credit && (r_outst < OUT_W'(MAX_OUTST));
   assign w_accept = w_req && fq.req_ready_i;
   assign w_resp   = fq.resp_valid_i && (r_outst != '0);
   assign w_drop   = w_resp && (r_discard != '0);
   assign w_push   = w_resp && !w_drop && !fq.flush_i;
   assign w_valid  = (r_count != '0);
   assign w_pop    = w_valid && fq.instr_ready_i;

   assign fq.req_o         = w_req;
   assign fq.req_addr_o    = r_pc;
   assign fq.instr_valid_o = w_valid;
   assign fq.instr_o       = w_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign fq.instr_pc_o    = w_valid ? r_fifo_pc[r_rd_ptr]   : '0;
   assign fq.misalign_o    = r_misalign;
   assign fq.count_o       = r_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_outst    <= '0;
         r_discard  <= '0;
         r_pend_wr  <= '0;
         r_pend_rd  <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= fq.flush_i && (fq.flush_pc_i[1:0] != 2'b00);
         if (fq.flush_i) begin
            // Everything still on the bus becomes stale and must be swallowed on return.
            r_pc      <= {fq.flush_pc_i[ADDR_W-1:2], 2'b00};
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pend_wr <= '0;
            r_pend_rd <= '0;
            r_outst   <= r_outst - OUT_W'(w_resp);
            r_discard <= r_outst - OUT_W'(w_resp);
         end else begin
            if (w_accept) begin
               r_pc      <= r_pc + ADDR_W'(INC);
               r_pend_wr <= pend_inc(r_pend_wr);
            end
            if (w_push) begin
               r_wr_ptr  <= r_wr_ptr + AW'(1);
               r_pend_rd <= pend_inc(r_pend_rd);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop) begin
               r_discard <= r_discard - OUT_W'(1);
            end
            r_outst <= r_outst + OUT_W'(w_accept) - OUT_W'(w_resp);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         end
      end
   end

   // NOTE: storage arrays carry no reset; pointers and counts alone decide what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= fq.resp_data_i;
         r_fifo_pc[r_wr_ptr]   <= r_pend_pc[r_pend_rd];
      end
      if (w_accept) begin
         r_pend_pc[r_pend_wr] <= r_pc;
      end
   end

   a_no_spurious_resp : assert property (@(posedge clk) disable iff (!rst_n)
      !(fq.resp_valid_i && (r_outst == '0)));

   a_bounds : assert property (@(posedge clk) disable iff (!rst_n)
      (r_count <= CNT_W'(DEPTH)) && (r_discard <= r_outst) && (r_outst <= OUT_W'(MAX_OUTST)));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomised checks for fetch_queue with an in-order bus model of
// configurable latency; returned data is the bitwise inverse of the low address word.
module tb_fetch_queue;
   localparam int          ADDR_W    = 64;
   localparam int          INSTR_W   = 32;
   localparam int          DEPTH     = 4;
   localparam int          MAX_OUTST = 2;
   localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } rsp_t;

   logic clk;
   logic rst_n;

   fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

   fetch_queue #(
      .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
      .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fq    (bus)
   );

   int unsigned n_tests;
   int unsigned n_fail;

   rsp_t        rsp_q     [$];
   logic [63:0] acc_q     [$];
   logic [63:0] got_pc    [$];
   logic [31:0] got_data  [$];
   int          got_epoch [$];
   logic [63:0] tgt_q     [$];

   int          cyc;
   int          last_due;
   int          epoch;
   bit          rdy_rand;
   bit          irdy_rand;
   logic        irdy;
   int          lat_min;
   int          lat_max;
   logic        flush_now;
   logic [63:0] flush_pc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst_n               = 1'b0;
      bus.flush_i         = 1'b0;
      bus.flush_pc_i      = '0;
      bus.req_ready_i     = 1'b0;
      bus.resp_valid_i    = 1'b0;
      bus.resp_data_i     = '0;
      bus.instr_ready_i   = 1'b0;
      rsp_q.delete();
      acc_q.delete();
      got_pc.delete();
      got_data.delete();
      got_epoch.delete();
      cyc       = 0;
      last_due  = 0;
      epoch     = 0;
      rdy_rand  = 1'b0;
      irdy_rand = 1'b0;
      irdy      = 1'b1;
      lat_min   = 1;
      lat_max   = 1;
      flush_now = 1'b0;
      flush_pc  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: drive inputs at the falling edge, then log what the next rising edge will do.
   task automatic cycle();
      logic [63:0] a;
      rsp_t        e;
      int          d;
      @(negedge clk);
      cyc++;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         a = rsp_q[0].addr;
         bus.resp_valid_i = 1'b1;
         bus.resp_data_i  = ~a[31:0];
         void'(rsp_q.pop_front());
      end else begin
         bus.resp_valid_i = 1'b0;
         bus.resp_data_i  = '0;
      end
      bus.req_ready_i   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.instr_ready_i = irdy_rand ? ($urandom_range(0, 3) != 0) : irdy;
      bus.flush_i       = flush_now;
      bus.flush_pc_i    = flush_pc;
      #1;
      if (bus.req_o && bus.req_ready_i) begin
         d = cyc + $urandom_range(lat_min, lat_max);
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         e.addr = bus.req_addr_o;
         e.due  = d;
         rsp_q.push_back(e);
         acc_q.push_back(bus.req_addr_o);
      end
      if (bus.instr_valid_o && bus.instr_ready_i) begin
         got_pc.push_back(bus.instr_pc_o);
         got_data.push_back(bus.instr_o);
         got_epoch.push_back(epoch);
      end
      if (flush_now) epoch++;
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.count_o); end
      n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.instr_valid_o); end
      n_tests++; if (bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 0", bus.instr_o); end
      n_tests++; if (bus.instr_pc_o !== 64'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h exp 0", bus.instr_pc_o); end
      n_tests++; if (bus.misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b exp 0", bus.misalign_o); end
      n_tests++; if (bus.req_addr_o !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h exp %h", bus.req_addr_o, RESET_PC); end
      n_tests++; if (bus.req_o !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b exp 1", bus.req_o); end
   endtask

   task automatic test_sequential();
      logic [63:0] e;
      apply_reset();
      repeat (12) cycle();
      n_tests++; if (acc_q.size() != 12) begin n_fail++; $display("FAIL seq_accepts: got %0d exp 12", acc_q.size()); end
      n_tests++; if (got_pc.size() != 10) begin n_fail++; $display("FAIL seq_delivered: got %0d exp 10", got_pc.size()); end
      for (int i = 0; i < acc_q.size() && i < 4; i++) begin
         e = RESET_PC + 64'(4 * i);
         n_tests++; if (acc_q[i] !== e) begin n_fail++; $display("FAIL seq_req_addr[%0d]: got %h exp %h", i, acc_q[i], e); end
      end
      for (int i = 0; i < got_pc.size(); i++) begin
         e = RESET_PC + 64'(4 * i);
         n_tests++; if (got_pc[i] !== e) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, got_pc[i], e); end
         n_tests++; if (got_data[i] !== ~e[31:0]) begin n_fail++; $display("FAIL seq_data[%0d]: got %h exp %h", i, got_data[i], ~e[31:0]); end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] e;
      apply_reset();
      irdy = 1'b0;
      repeat (20) cycle();
      n_tests++; if (bus.count_o !== 3'd4) begin n_fail++; $display("FAIL hold_count: got %0d exp 4", bus.count_o); end
      n_tests++; if (bus.req_o !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b exp 0", bus.req_o); end
      n_tests++; if (acc_q.size() != 4) begin n_fail++; $display("FAIL hold_accepts: got %0d exp 4", acc_q.size()); end
      n_tests++; if (got_pc.size() != 0) begin n_fail++; $display("FAIL hold_delivered: got %0d exp 0", got_pc.size()); end
      n_tests++; if (bus.instr_pc_o !== RESET_PC) begin n_fail++; $display("FAIL hold_head_pc: got %h exp %h", bus.instr_pc_o, RESET_PC); end
      n_tests++; if (bus.instr_o !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL hold_head_data: got %h exp 7fffffff", bus.instr_o); end
      irdy = 1'b1;
      repeat (8) cycle();
      n_tests++; if (got_pc.size() < 4) begin n_fail++; $display("FAIL drain_delivered: got %0d exp >=4", got_pc.size()); end
      for (int i = 0; i < got_pc.size(); i++) begin
         e = RESET_PC + 64'(4 * i);
         n_tests++; if (got_pc[i] !== e) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h exp %h", i, got_pc[i], e); end
         n_tests++; if (got_data[i] !== ~e[31:0]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h exp %h", i, got_data[i], ~e[31:0]); end
      end
   endtask

   task automatic test_flush_inflight();
      apply_reset();
      lat_min = 3; lat_max = 3;
      repeat (2) cycle();
      flush_now = 1'b1; flush_pc = 64'h0000_0000_8000_0100;
      cycle();
      n_tests++; if (bus.req_o !== 1'b0) begin n_fail++; $display("FAIL flush_req_in_flush_cycle: got %b exp 0", bus.req_o); end
      flush_now = 1'b0;
      cycle();
      n_tests++; if (bus.req_addr_o !== 64'h8000_0100) begin n_fail++; $display("FAIL flush_req_addr: got %h exp 80000100", bus.req_addr_o); end
      n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d exp 0", bus.count_o); end
      n_tests++; if (bus.misalign_o !== 1'b0) begin n_fail++; $display("FAIL flush_misalign: got %b exp 0", bus.misalign_o); end
      repeat (14) cycle();
      n_tests++; if (acc_q.size() < 4) begin n_fail++; $display("FAIL flush_accepts: got %0d exp >=4", acc_q.size()); end
      else begin
         n_tests++; if (acc_q[2] !== 64'h8000_0100) begin n_fail++; $display("FAIL flush_acc2: got %h exp 80000100", acc_q[2]); end
         n_tests++; if (acc_q[3] !== 64'h8000_0104) begin n_fail++; $display("FAIL flush_acc3: got %h exp 80000104", acc_q[3]); end
      end
      n_tests++; if (got_pc.size() < 2) begin n_fail++; $display("FAIL flush_delivered: got %0d exp >=2", got_pc.size()); end
      else begin
         n_tests++; if (got_pc[0] !== 64'h8000_0100) begin n_fail++; $display("FAIL flush_pc0: got %h exp 80000100", got_pc[0]); end
         n_tests++; if (got_pc[1] !== 64'h8000_0104) begin n_fail++; $display("FAIL flush_pc1: got %h exp 80000104", got_pc[1]); end
         n_tests++; if (got_data[0] !== 32'h7FFF_FEFF) begin n_fail++; $display("FAIL flush_data0: got %h exp 7ffffeff", got_data[0]); end
      end
   endtask

   task automatic test_flush_with_resp();
      apply_reset();
      lat_min = 2; lat_max = 2;
      repeat (2) cycle();
      flush_now = 1'b1; flush_pc = 64'h0000_0000_8000_0200;
      cycle();
      n_tests++; if (bus.resp_valid_i !== 1'b1) begin n_fail++; $display("FAIL fresp_setup_resp: got %b exp 1", bus.resp_valid_i); end
      flush_now = 1'b0;
      cycle();
      n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL fresp_count_a: got %0d exp 0", bus.count_o); end
      n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL fresp_valid_a: got %b exp 0", bus.instr_valid_o); end
      cycle();
      n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL fresp_count_b: got %0d exp 0", bus.count_o); end
      repeat (8) cycle();
      n_tests++; if (acc_q.size() < 3) begin n_fail++; $display("FAIL fresp_accepts: got %0d exp >=3", acc_q.size()); end
      else begin
         n_tests++; if (acc_q[2] !== 64'h8000_0200) begin n_fail++; $display("FAIL fresp_acc2: got %h exp 80000200", acc_q[2]); end
      end
      n_tests++; if (got_pc.size() < 1) begin n_fail++; $display("FAIL fresp_delivered: got %0d exp >=1", got_pc.size()); end
      else begin
         n_tests++; if (got_pc[0] !== 64'h8000_0200) begin n_fail++; $display("FAIL fresp_pc0: got %h exp 80000200", got_pc[0]); end
         n_tests++; if (got_data[0] !== 32'h7FFF_FDFF) begin n_fail++; $display("FAIL fresp_data0: got %h exp 7ffffdff", got_data[0]); end
      end
   endtask

   task automatic test_misalign();
      int first;
      apply_reset();
      repeat (3) cycle();
      flush_now = 1'b1; flush_pc = 64'h0000_0000_8000_0102;
      cycle();
      flush_now = 1'b0;
      cycle();
      n_tests++; if (bus.misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b exp 1", bus.misalign_o); end
      n_tests++; if (bus.req_addr_o !== 64'h8000_0100) begin n_fail++; $display("FAIL mis_req_addr: got %h exp 80000100", bus.req_addr_o); end
      cycle();
      n_tests++; if (bus.misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %b exp 0", bus.misalign_o); end
      repeat (6) cycle();
      first = -1;
      for (int i = 0; i < got_pc.size(); i++) if (first < 0 && got_epoch[i] == 1) first = i;
      n_tests++; if (first < 0) begin n_fail++; $display("FAIL mis_delivered: got none exp >=1"); end
      else begin
         n_tests++; if (got_pc[first] !== 64'h8000_0100) begin n_fail++; $display("FAIL mis_first_pc: got %h exp 80000100", got_pc[first]); end
      end
   endtask

   task automatic test_random();
      logic [63:0] e;
      logic [63:0] t;
      int          cur_ep;
      apply_reset();
      rdy_rand = 1'b1; irdy_rand = 1'b1;
      lat_min = 1; lat_max = 3;
      tgt_q.delete();
      tgt_q.push_back(RESET_PC);
      for (int i = 0; i < 400; i++) begin
         flush_now = ($urandom_range(0, 19) == 0);
         if (flush_now) begin
            t = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd2;
            flush_pc = t;
            tgt_q.push_back({t[63:2], 2'b00});
         end
         cycle();
      end
      flush_now = 1'b0;
      repeat (3) cycle();
      n_tests++; if (got_pc.size() < 50) begin n_fail++; $display("FAIL rand_progress: got %0d exp >=50", got_pc.size()); end
      cur_ep = -1;
      e = '0;
      for (int i = 0; i < got_pc.size(); i++) begin
         if (got_epoch[i] != cur_ep) begin
            cur_ep = got_epoch[i];
            e = tgt_q[cur_ep];
         end
         n_tests++; if (got_pc[i] !== e) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h exp %h", i, got_pc[i], e); end
         n_tests++; if (got_data[i] !== ~e[31:0]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h exp %h", i, got_data[i], ~e[31:0]); end
         e = e + 64'd4;
      end
      // Reset mid-burst, asynchronously, away from any clock edge.
      irdy_rand = 1'b0; irdy = 1'b0;
      repeat (4) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d exp 0", bus.count_o); end
      n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b exp 0", bus.instr_valid_o); end
      n_tests++; if (bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL midrst_instr: got %h exp 0", bus.instr_o); end
      n_tests++; if (bus.instr_pc_o !== 64'h0) begin n_fail++; $display("FAIL midrst_instr_pc: got %h exp 0", bus.instr_pc_o); end
      n_tests++; if (bus.req_addr_o !== RESET_PC) begin n_fail++; $display("FAIL midrst_req_addr: got %h exp %h", bus.req_addr_o, RESET_PC); end
      n_tests++; if (bus.misalign_o !== 1'b0) begin n_fail++; $display("FAIL midrst_misalign: got %b exp 0", bus.misalign_o); end
      apply_reset();
      repeat (4) cycle();
      n_tests++; if (got_pc.size() < 1) begin n_fail++; $display("FAIL postrst_delivered: got %0d exp >=1", got_pc.size()); end
      else begin
         n_tests++; if (got_pc[0] !== RESET_PC) begin n_fail++; $display("FAIL postrst_pc0: got %h exp %h", got_pc[0], RESET_PC); end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_flush_inflight();
      test_flush_with_resp();
      test_misalign();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
